// File: rtl/ex_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : ex_mem_stage
// Description : EX->MEM pipeline register built as a 2-entry in-order buffer
//               with valid/ready handshakes on both sides, flush, and an
//               overflow capture path for the signed-add select code.
//               Optional overflow trap enabled by macro EX_MEM_OVF_TRAP_EN:
//               trapped entries lose their register write and set a sticky
//               flag that is cleared by ovf_clr.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_mem_stage #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic              in_overflow,
  input  logic [2:0]        in_sel_alu,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              in_wr_en,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [RD_W-1:0]   out_rd,
  output logic              out_wr_en,
  output logic              out_overflow,
  output logic              ovf_sticky,
  input  logic              ovf_clr
);

  // Occupancy encoding of the buffer
  localparam logic [1:0] c_EMPTY = 2'd0;
  localparam logic [1:0] c_ONE   = 2'd1;
  localparam logic [1:0] c_TWO   = 2'd2;

  // Only this select code reports a meaningful overflow
  localparam logic [2:0] c_SEL_OVF = 3'b101;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [RD_W-1:0]   rd;
    logic              wr_en;
    logic              ovf;
  } entry_t;

  logic [1:0] state_q, state_d;
  entry_t     head_q, head_d;   // oldest entry, always presented on out_*
  entry_t     tail_q, tail_d;   // second entry, only meaningful in c_TWO
  entry_t     w_in_entry;
  logic       w_ovf_cap;
  logic       w_push;
  logic       w_pop;

  assign w_ovf_cap = in_overflow & (in_sel_alu == c_SEL_OVF);

  // Ready/valid come straight from registered occupancy: no input-to-output
  // combinational path through the handshake.
  assign in_ready  = (state_q != c_TWO);
  assign out_valid = (state_q != c_EMPTY);

  assign w_push = in_valid & in_ready & ~flush;
  assign w_pop  = out_valid & out_ready & ~flush;

  // Build the entry to be stored from the current ALU inputs
  always_comb begin
    w_in_entry.result = in_result;
    w_in_entry.rd     = in_rd;
    w_in_entry.ovf    = w_ovf_cap;
`ifdef EX_MEM_OVF_TRAP_EN
    w_in_entry.wr_en  = in_wr_en & ~w_ovf_cap;
`else
    w_in_entry.wr_en  = in_wr_en;
`endif
  end

  // Next-state and storage update for the 2-entry buffer
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      c_EMPTY: begin
        if (w_push) begin
          head_d  = w_in_entry;
          state_d = c_ONE;
        end
      end
      c_ONE: begin
        if (w_push && w_pop) begin
          // Old head leaves as the new one arrives: stay at one entry.
          head_d = w_in_entry;
        end else if (w_push) begin
          tail_d  = w_in_entry;
          state_d = c_TWO;
        end else if (w_pop) begin
          state_d = c_EMPTY;
        end
      end
      c_TWO: begin
        // in_ready is low here, so only a pop can happen.
        if (w_pop) begin
          head_d  = tail_q;
          state_d = c_ONE;
        end
      end
      default: begin
        state_d = c_EMPTY;
      end
    endcase
    if (flush) begin
      state_d = c_EMPTY;
    end
  end

  // Occupancy register; reset discards every buffered entry
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= c_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Payload registers; contents are qualified by occupancy so need no reset
  always_ff @(posedge clk) begin
    head_q <= head_d;
    tail_q <= tail_d;
  end

  assign out_result   = head_q.result;
  assign out_rd       = head_q.rd;
  // Gate the control-like fields so an empty stage never requests a write.
  assign out_wr_en    = out_valid & head_q.wr_en;
  assign out_overflow = out_valid & head_q.ovf;

`ifdef EX_MEM_OVF_TRAP_EN
  logic ovf_sticky_q, ovf_sticky_d;

  // Set on a trapped push wins over a simultaneous clear
  always_comb begin
    ovf_sticky_d = ovf_sticky_q;
    if (w_push && w_ovf_cap) begin
      ovf_sticky_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_sticky_d = 1'b0;
    end
  end

  // Sticky overflow flag register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_sticky_q <= 1'b0;
    end else begin
      ovf_sticky_q <= ovf_sticky_d;
    end
  end

  assign ovf_sticky = ovf_sticky_q;
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = ovf_clr;
  assign ovf_sticky     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_mem_stage
// Description : Self-checking bench for ex_mem_stage. Expected entries are
//               queued when a push is driven and popped when the stage
//               presents them while out_ready is high.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_mem_stage;

`ifdef EX_MEM_OVF_TRAP_EN
  localparam bit c_TRAP = 1'b1;
`else
  localparam bit c_TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic        in_overflow;
  logic [2:0]  in_sel_alu;
  logic [4:0]  in_rd;
  logic        in_wr_en;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_wr_en;
  logic        out_overflow;
  logic        ovf_sticky;
  logic        ovf_clr;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        we;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ex_mem_stage #(.DATA_W(32), .RD_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_overflow(in_overflow),
    .in_sel_alu(in_sel_alu), .in_rd(in_rd), .in_wr_en(in_wr_en),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd),
    .out_wr_en(out_wr_en), .out_overflow(out_overflow),
    .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr)
  );

  // Advance one clock; outputs are sampled 1 ns after the rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Drive a push and enqueue what the stage must later present
  task automatic drive_push(input logic [31:0] res, input logic [4:0] rd,
                            input logic we, input logic [2:0] sel,
                            input logic ovf, input bit expect_accept);
    exp_t x;
    in_valid    = 1'b1;
    in_result   = res;
    in_rd       = rd;
    in_wr_en    = we;
    in_sel_alu  = sel;
    in_overflow = ovf;
    x.res = res;
    x.rd  = rd;
    x.ovf = ovf & (sel == 3'b101);
    x.we  = c_TRAP ? (we & ~x.ovf) : we;
    if (expect_accept) sb.push_back(x);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; in_result = 32'hDEAD; in_rd = 5'd1;
    in_wr_en = 1'b1; in_sel_alu = 3'b101; in_overflow = 1'b1;
    flush = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0;
    cyc(); cyc();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_wr_en !== 1'b0 || out_overflow !== 1'b0) begin errors++; $display("FAIL reset_out_ctrl: got we=%b ovf=%b expected 0 0", out_wr_en, out_overflow); end
    checks++; if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL reset_sticky: got %b expected 0", ovf_sticky); end
    in_valid = 1'b0;
    rst_n = 1'b1;
    cyc();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_idle_valid: got %b expected 0", out_valid); end
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    drive_push(32'h0000_0005, 5'd3, 1'b1, 3'b001, 1'b0, 1'b1);
    cyc();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", out_valid); end
    e = sb.pop_front();
    checks++; if ({out_result, out_rd, out_wr_en, out_overflow} !== {e.res, e.rd, e.we, e.ovf})
      begin errors++; $display("FAIL single_entry: got res=%h rd=%0d we=%b ovf=%b expected res=%h rd=%0d we=%b ovf=%b",
                               out_result, out_rd, out_wr_en, out_overflow, e.res, e.rd, e.we, e.ovf); end
    cyc();
    checks++; if (out_valid !== 1'b0 || out_wr_en !== 1'b0) begin errors++; $display("FAIL single_drained: got valid=%b we=%b expected 0 0", out_valid, out_wr_en); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive_push(32'h11, 5'd1, 1'b1, 3'b000, 1'b0, 1'b1);
    cyc();
    drive_push(32'h22, 5'd2, 1'b1, 3'b010, 1'b0, 1'b1);
    cyc();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_full: got %b expected 0", in_ready); end
    drive_push(32'h33, 5'd4, 1'b1, 3'b000, 1'b0, 1'b0);
    cyc();
    in_valid = 1'b0;
    checks++; if (out_result !== sb[0].res) begin errors++; $display("FAIL bp_head_hold: got %h expected %h", out_result, sb[0].res); end
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_drain_valid%0d: got %b expected 1", i, out_valid); end
      e = sb.pop_front();
      checks++; if ({out_result, out_rd} !== {e.res, e.rd}) begin errors++; $display("FAIL bp_drain_entry%0d: got res=%h rd=%0d expected res=%h rd=%0d", i, out_result, out_rd, e.res, e.rd); end
      cyc();
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_third_dropped: got valid=%b expected 0", out_valid); end
  endtask

  task automatic test_overflow();
    out_ready = 1'b0;
    drive_push(32'h8000_0000, 5'd7, 1'b1, 3'b101, 1'b1, 1'b1);
    cyc();
    in_valid = 1'b0;
    checks++; if ({out_overflow, out_wr_en} !== {sb[0].ovf, sb[0].we}) begin errors++; $display("FAIL ovf_fields: got ovf=%b we=%b expected ovf=%b we=%b", out_overflow, out_wr_en, sb[0].ovf, sb[0].we); end
    cyc();
    checks++; if (ovf_sticky !== c_TRAP) begin errors++; $display("FAIL ovf_sticky_set: got %b expected %b", ovf_sticky, c_TRAP); end
    ovf_clr = 1'b1;
    cyc();
    ovf_clr = 1'b0;
    checks++; if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL ovf_sticky_clr: got %b expected 0", ovf_sticky); end
    out_ready = 1'b1;
    e = sb.pop_front();
    checks++; if (out_result !== e.res || out_overflow !== e.ovf) begin errors++; $display("FAIL ovf_pop: got res=%h ovf=%b expected res=%h ovf=%b", out_result, out_overflow, e.res, e.ovf); end
    // A trapped push with a simultaneous clear must leave the flag set.
    drive_push(32'h7FFF_FFFF, 5'd8, 1'b1, 3'b101, 1'b1, 1'b1);
    ovf_clr = 1'b1;
    cyc();
    ovf_clr = 1'b0;
    checks++; if (ovf_sticky !== c_TRAP) begin errors++; $display("FAIL ovf_set_beats_clr: got %b expected %b", ovf_sticky, c_TRAP); end
    e = sb.pop_front();
    checks++; if (out_wr_en !== e.we || out_overflow !== e.ovf) begin errors++; $display("FAIL ovf_second: got we=%b ovf=%b expected we=%b ovf=%b", out_wr_en, out_overflow, e.we, e.ovf); end
    // Overflow on a non-add select is not captured and leaves the flag alone.
    drive_push(32'h1234_5678, 5'd9, 1'b1, 3'b110, 1'b1, 1'b1);
    cyc();
    in_valid = 1'b0;
    e = sb.pop_front();
    checks++; if ({out_overflow, out_wr_en, out_result} !== {e.ovf, e.we, e.res}) begin errors++; $display("FAIL ovf_other_sel: got ovf=%b we=%b res=%h expected ovf=%b we=%b res=%h", out_overflow, out_wr_en, out_result, e.ovf, e.we, e.res); end
    checks++; if (ovf_sticky !== c_TRAP) begin errors++; $display("FAIL ovf_other_sticky: got %b expected %b", ovf_sticky, c_TRAP); end
    ovf_clr = 1'b1;
    cyc();
    ovf_clr = 1'b0;
    checks++; if (out_valid !== 1'b0 || ovf_sticky !== 1'b0) begin errors++; $display("FAIL ovf_final: got valid=%b sticky=%b expected 0 0", out_valid, ovf_sticky); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive_push(32'hA0, 5'd10, 1'b1, 3'b101, 1'b1, 1'b1);
    cyc();
    drive_push(32'hB0, 5'd11, 1'b1, 3'b000, 1'b0, 1'b1);
    cyc();
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL flush_pre_full: got ready=%b valid=%b expected 0 1", in_ready, out_valid); end
    drive_push(32'hC0, 5'd12, 1'b1, 3'b000, 1'b0, 1'b0);
    flush = 1'b1;
    out_ready = 1'b1;
    cyc();
    flush = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    checks++; if ({out_valid, in_ready, out_wr_en} !== 3'b010) begin errors++; $display("FAIL flush_empty: got valid=%b ready=%b we=%b expected 0 1 0", out_valid, in_ready, out_wr_en); end
    checks++; if (ovf_sticky !== c_TRAP) begin errors++; $display("FAIL flush_keeps_sticky: got %b expected %b", ovf_sticky, c_TRAP); end
    cyc();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_input_dropped: got %b expected 0", out_valid); end
    ovf_clr = 1'b1;
    cyc();
    ovf_clr = 1'b0;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 3)
        drive_push(32'h8000_0000 + 32'(i), 5'(i), 1'b1, 3'b101, 1'b1, 1'b1);
      else
        drive_push(32'(i) * 32'h0101 + 32'h7, 5'(i + 16), 1'(i % 2), 3'b000, 1'b0, 1'b1);
      cyc();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid%0d: got %b expected 1", i, out_valid); end
      e = sb.pop_front();
      checks++; if ({out_result, out_rd, out_wr_en, out_overflow} !== {e.res, e.rd, e.we, e.ovf})
        begin errors++; $display("FAIL b2b_entry%0d: got res=%h rd=%0d we=%b ovf=%b expected res=%h rd=%0d we=%b ovf=%b",
                                 i, out_result, out_rd, out_wr_en, out_overflow, e.res, e.rd, e.we, e.ovf); end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    checks++; if (ovf_sticky !== c_TRAP) begin errors++; $display("FAIL b2b_sticky: got %b expected %b", ovf_sticky, c_TRAP); end
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    sb.delete();
    checks++; if ({out_valid, ovf_sticky, in_ready} !== 3'b001) begin errors++; $display("FAIL b2b_reset: got valid=%b sticky=%b ready=%b expected 0 0 1", out_valid, ovf_sticky, in_ready); end
    cyc();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_post_reset: got %b expected 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_overflow();
    test_flush();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, ALU result width.
REQ-002 SHALL have parameter RD_W, default 5, destination register index width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  upstream ALU result valid.
REQ-006 SHALL have port in_ready  output  1  stage can accept an entry this cycle.
REQ-007 SHALL have port in_result  input  DATA_W  ALU outp.
REQ-008 SHALL have port in_overflow  input  1  ALU overflow.
REQ-009 SHALL have port in_sel_alu  input  3  ALU select code used for this result.
REQ-010 SHALL have port in_rd  input  RD_W  destination register index.
REQ-011 SHALL have port in_wr_en  input  1  register write requested.
REQ-012 SHALL have port flush  input  1  discard all buffered entries.
REQ-013 SHALL have port out_valid  output  1  head entry valid.
REQ-014 SHALL have port out_ready  input  1  downstream accepts head entry.
REQ-015 SHALL have ports out_result (DATA_W), out_rd (RD_W), out_wr_en (1), out_overflow (1), all outputs, head-entry fields.
REQ-016 SHALL have port ovf_sticky  output  1  overflow seen since last clear.
REQ-017 SHALL have port ovf_clr  input  1  clear ovf_sticky.

Function
REQ-018 SHALL hold a 2-entry in-order buffer; occupancy states EMPTY(0), ONE(1), TWO(2).
REQ-019 Push SHALL occur when in_valid & in_ready & ~flush; pop SHALL occur when out_valid & out_ready & ~flush.
REQ-020 in_ready SHALL be 1 in EMPTY and ONE, 0 in TWO; depends only on registered state.
REQ-021 out_valid SHALL be 1 exactly when occupancy is nonzero; out_* fields SHALL show the oldest entry, and SHALL NOT change while out_valid & ~out_ready.
REQ-022 Latency: entry pushed at edge N SHALL appear at out_* with out_valid=1 after edge N (cycle N+1) when buffer was EMPTY.
REQ-023 Transitions: EMPTY-push->ONE; ONE-push-only->TWO; ONE-pop-only->EMPTY; ONE-push&pop->ONE (new entry becomes head); TWO-pop->ONE; no-op holds state.
REQ-024 Sustained in_valid=1, out_ready=1 SHALL yield one entry per cycle with no bubbles.
REQ-025 Captured overflow SHALL be in_overflow & (in_sel_alu == 3'b101); overflow for all other select codes SHALL be stored as 0.
REQ-026 out_result and out_rd SHALL be stored unmodified; out_overflow SHALL be the captured overflow.
REQ-027 flush SHALL set occupancy to EMPTY at the next edge, has priority over push and pop, and SHALL NOT affect ovf_sticky.
REQ-028 Buffer storage contents when out_valid=0 are don't-care, but out_wr_en SHALL read 0 when out_valid=0.

Reset
REQ-029 With rst_n=0 at an edge: occupancy EMPTY, out_valid=0, out_wr_en=0, out_overflow=0, ovf_sticky=0, in_ready=1 from the following cycle.
REQ-030 Reset SHALL override push, pop, flush and ovf_clr in the same cycle; reset mid-stream discards all entries.

Configuration
REQ-031 Macro EX_MEM_OVF_TRAP_EN SHALL select the overflow trap feature.
REQ-032 With EX_MEM_OVF_TRAP_EN defined: a pushed entry with captured overflow=1 SHALL be stored with wr_en forced to 0, and ovf_sticky SHALL set at that push edge; ovf_sticky clears on ovf_clr; simultaneous set and clear SHALL leave ovf_sticky=1.
REQ-033 Without EX_MEM_OVF_TRAP_EN: wr_en stored as in_wr_en unchanged, ovf_sticky tied to 0, ovf_clr ignored; out_overflow still reported per REQ-025.

Verification
REQ-034 Reset, then push result 0x0000_0005, rd=3, wr_en=1, sel=3'b001 with out_ready=1 -> next cycle out_valid=1, out_result=0x5, out_rd=3, out_wr_en=1; following cycle out_valid=0.
REQ-035 out_ready=0, push A=0x11, B=0x22 on consecutive cycles -> in_ready=0 after second push; third in_valid ignored; raise out_ready -> A then B, in order.
REQ-036 Push sel=3'b101, in_overflow=1, wr_en=1, result 0x8000_0000 -> out_overflow=1; with EX_MEM_OVF_TRAP_EN out_wr_en=0 and ovf_sticky=1 until ovf_clr pulse; without, out_wr_en=1, ovf_sticky=0.
REQ-037 Push sel=3'b110 with in_overflow=1 -> out_overflow=0, ovf_sticky unchanged.
REQ-038 Occupancy TWO, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed-cycle input not stored.
REQ-039 Stream 8 entries with out_ready=1 continuously, then drop rst_n with 1 entry buffered -> 8 outputs on consecutive cycles; after reset out_valid=0, ovf_sticky=0.
